// File: rtl/sqr_pp_seq_reduce.sv
// Sequential partial-product reducer for the signed squarer: folds one row per
// cycle into a carry-save pair, then a single carry-propagate add yields P.
module sqr_pp_seq_reduce #(
  parameter int width = 8
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               InValid,
  output logic                               InReady,
  input  logic [(width/2+1)*2*width-1:0]     PP,
  output logic                               OutValid,
  input  logic                               OutReady,
  output logic [2*width-1:0]                 P,
  output logic                               Busy
);
  localparam int rows   = width/2 + 1;
  localparam int widthP = 2*width;
  localparam int cntW   = $clog2(rows);
  localparam logic [cntW-1:0] last_row = cntW'(rows-1);

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, OUT} state_t;

  state_t                         state, state_nxt;
  logic [rows-1:0][widthP-1:0]    row_q;
  logic [cntW-1:0]                cnt;
  logic [widthP-1:0]              s, c, cur;
  logic                           accept;

  assign accept = InValid & InReady;
  assign cur    = row_q[cnt];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)          state_nxt = ACCUM;
      ACCUM:   if (cnt == last_row) state_nxt = FINAL;
      FINAL:                        state_nxt = OUT;
      OUT:     if (OutReady)        state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // InReady masks RST so nothing is offered while the block is held in reset.
  always_comb begin
    InReady = (state == IDLE) & ~RST;
    Busy    = (state != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      row_q    <= '0;
      cnt      <= '0;
      s        <= '0;
      c        <= '0;
      P        <= '0;
      OutValid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          row_q <= PP;
          s     <= '0;
          c     <= '0;
          cnt   <= '0;
        end
        ACCUM: begin
          // 3:2 compression; carry out of the top bit is dropped (mod 2^widthP)
          s   <= s ^ c ^ cur;
          c   <= ((s & c) | (s & cur) | (c & cur)) << 1;
          cnt <= cnt + 1'b1;
        end
        FINAL: begin
          P        <= s + c;
          OutValid <= 1'b1;
        end
        OUT: if (OutReady) OutValid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/sqr_pp_seq_reduce.md
# sqr_pp_seq_reduce

Sequential partial-product reducer for the signed squarer. It sits directly downstream of the signed-squarer partial-product generator. It accepts the generator's flattened row vector through a valid/ready handshake and reduces the rows one per cycle in a carry-save accumulator. A final carry-propagate add then produces the 2·width-bit signed square, which is held behind an output valid/ready handshake.

## Interface
- width, default 8: operand width of the squared value; must be ≥ 2 (odd values allowed)
- Derived constants (not parameters):
  - rows = width/2+1 (integer division)
  - widthP = 2*width
  - cntW = $clog2(rows)
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  asynchronous, active-high reset
- InValid  input  1  PP holds a valid row set
- InReady  output  1  block can accept a row set
- PP  input  rows*widthP  flattened partial-product rows; row r occupies bits [r*widthP +: widthP]
- OutValid  output  1  P holds a completed square
- OutReady  input  1  consumer accepts P
- P  output  widthP  result, two's-complement square of the generator's operand
- Busy  output  1  high in any state other than IDLE

## Operation
- States and transitions:
  - IDLE → ACCUM on an input handshake (InValid & InReady at an edge)
  - ACCUM → FINAL after the last row has been consumed
  - FINAL → OUT unconditionally
  - OUT → IDLE on an output handshake (OutValid & OutReady at an edge)
- On input handshake:
  - capture all of PP into the row register
  - clear S and C to 0
  - clear the row counter to 0
- ACCUM, on each edge:
  - 3:2 compress S, C, row[cnt]
  - S ← S ^ C ^ row
  - C ← majority(S, C, row) << 1, with the bit shifted out of position widthP-1 discarded
  - cnt ← cnt+1
  - after the edge where cnt == rows-1, go to FINAL
- FINAL, on its edge:
  - P ← (S + C) mod 2^widthP
  - OutValid ← 1
- All arithmetic is modulo 2^widthP. Generator correction terms make the modular row sum equal the signed square exactly; the block itself applies no sign extension or correction.
- OUT:
  - P and OutValid are held stable while OutReady is low, for any number of cycles
  - on handshake, OutValid ← 0; P keeps its last value
- InReady = (state == IDLE) & ~RST. Input is never accepted in ACCUM, FINAL or OUT. PP is sampled only at the acceptance edge and is don't-care otherwise.
- InValid/OutReady activity outside the states named above has no effect.
- Reset (asserted at any time, including mid-ACCUM or in OUT) takes effect immediately:
  - state ← IDLE
  - cnt, S, C, row register, P ← 0
  - OutValid ← 0, Busy ← 0
  - any in-flight result is discarded, not emitted
- After RST deasserts, the first input can be accepted at the first rising edge.

## Timing
- Input accepted at edge k:
  - ACCUM row edges are k+1 … k+rows
  - FINAL edge is k+rows+1
  - OutValid rises after edge k+rows+1
- Latency from acceptance edge to OutValid is rows+1 cycles; width=8 gives 6.
- Output handshake at edge m: InReady is high after m; the earliest next acceptance is edge m+1.
- Back-to-back initiation interval with OutReady tied high is rows+3 cycles; width=8 gives 8.
- Outputs P, OutValid and Busy are registered or state-decoded. InReady is state-decoded. There are no combinational paths from InValid or OutReady to any output.

## Test plan
Bench drives PP from a signed-squarer partial-product generator instance with width=8; expect OutValid exactly 6 cycles after acceptance.
- Single operands, OutReady held high:
  - X=0x80 (-128) → P=0x4000
  - X=0x7F (127) → P=0x3F01
  - X=0xFF (-1) → P=0x0001
  - X=0x00 → P=0x0000
- Backpressure: X=0xFD (-3), OutReady low for 10 cycles after OutValid:
  - P stays 0x0009 and OutValid stays high throughout
  - InReady stays 0 and a second InValid is ignored
  - OutReady high → handshake, then the next input is accepted one edge later
- Back-to-back: 20 random operands with InValid and OutReady held high:
  - each P equals X² (signed)
  - acceptances are exactly 8 cycles apart
- Reset mid-op: accept X=0x55, assert RST 3 edges later:
  - OutValid, P, Busy → 0 immediately, InReady → 0 while RST is high
  - after release, InReady=1 and X=0x10 → P=0x0100 with no stale output
- Parameter sweep: width=3, 5, 16, exhaustive (width 3/5) or 1000 random (width 16):
  - P = X² mod 2^(2·width)
  - latency = width/2+2 cycles
